// File: rtl/board_pkg.sv
// Shared constants for the board scanner: storage modes, cell byte layout,
// tank directions, palette and the scanner FSM state type.
package board_pkg;

  localparam logic [3:0] MODE_READ = 4'b0000;
  localparam logic [3:0] MODE_NOP  = 4'b1110;

  localparam int WALL    = 7;
  localparam int TANK1   = 6;
  localparam int TANK2   = 5;
  localparam int PROJ    = 4;
  localparam int DIR1_HI = 3;
  localparam int DIR1_LO = 2;
  localparam int DIR2_HI = 1;
  localparam int DIR2_LO = 0;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_WHITE  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAW,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/cell_colour_decode.sv
// Combinational cell byte -> pixel colour. With DIRECTION_MARK_EN defined,
// a tank cell gets one green barrel pixel on the side its dir field points to.
module cell_colour_decode
  import board_pkg::*;
#(
  parameter int CELL_PX = 4,
  parameter int PW      = $clog2(CELL_PX)
) (
  input  logic [7:0]    cell_i,
  input  logic [PW-1:0] px_i,
  input  logic [PW-1:0] py_i,
  output logic [2:0]    colour_o
);

  logic [2:0] body;

  always_comb begin
    body = COL_BLACK;
    if (cell_i[TANK1])      body = COL_RED;
    else if (cell_i[TANK2]) body = COL_BLUE;
    else if (cell_i[PROJ])  body = COL_YELLOW;
    else if (cell_i[WALL])  body = COL_WHITE;
  end

`ifdef DIRECTION_MARK_EN
  localparam logic [PW-1:0] MID  = PW'(CELL_PX / 2);
  localparam logic [PW-1:0] LAST = PW'(CELL_PX - 1);

  logic [1:0] dir;
  logic       on_barrel;

  always_comb begin
    // tank1 wins the cell, so its direction field chooses the barrel
    dir       = cell_i[TANK1] ? cell_i[DIR1_HI:DIR1_LO] : cell_i[DIR2_HI:DIR2_LO];
    on_barrel = 1'b0;
    case (dir)
      DIR_UP:    on_barrel = (px_i == MID)  && (py_i == '0);
      DIR_DOWN:  on_barrel = (px_i == MID)  && (py_i == LAST);
      DIR_LEFT:  on_barrel = (px_i == '0)   && (py_i == MID);
      DIR_RIGHT: on_barrel = (px_i == LAST) && (py_i == MID);
      default:   on_barrel = 1'b0;
    endcase
    colour_o = ((cell_i[TANK1] | cell_i[TANK2]) && on_barrel) ? COL_GREEN : body;
  end
`else
  logic unused_dir;
  assign unused_dir = ^{cell_i[3:0], px_i, py_i};
  assign colour_o   = body;
`endif

endmodule

// File: rtl/board_reader.sv
// Scans the 16x16 board from storage and plots each cell as a CELL_PX square.
// Optional barrel marking on tank cells is enabled by DIRECTION_MARK_EN.
module board_reader
  import board_pkg::*;
#(
  parameter int CELL_PX      = 4,
  parameter int X_OFFSET     = 48,
  parameter int Y_OFFSET     = 28,
  parameter int READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ram_q,
  output logic [3:0] mode,
  output logic [7:0] address,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output state_t     dbg_state_o
);

  // Handshake: start is a single-cycle request sampled only in IDLE;
  // busy/plot/done are decoded from the current state, no back-pressure.
  localparam int              PW        = $clog2(CELL_PX);
  localparam int              WW        = 4;
  localparam logic [PW-1:0]   PX_LAST   = PW'(CELL_PX - 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(READ_LATENCY - 2);

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [PW-1:0]   px_q, px_d;
  logic [PW-1:0]   py_q, py_d;
  logic [7:0]      cell_q, cell_d;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;

  logic [7:0]      x_live;
  logic [6:0]      y_live;
  logic [2:0]      colour_live;

  cell_colour_decode #(
    .CELL_PX (CELL_PX),
    .PW      (PW)
  ) u_decode (
    .cell_i   (cell_q),
    .px_i     (px_q),
    .py_i     (py_q),
    .colour_o (colour_live)
  );

  assign x_live = 8'(X_OFFSET) + 8'({addr_q[3:0], {PW{1'b0}}}) + 8'(px_q);
  assign y_live = 7'(Y_OFFSET) + 7'({addr_q[7:4], {PW{1'b0}}}) + 7'(py_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    px_d    = px_q;
    py_d    = py_q;
    cell_d  = cell_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          addr_d  = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          cell_d  = ram_q;
          px_d    = '0;
          py_d    = '0;
          state_d = ST_DRAW;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DRAW: begin
        if (px_q == PX_LAST) begin
          px_d = '0;
          if (py_q == PX_LAST) begin
            // the last cell ends the frame without wrapping the address
            if (addr_q == 8'hFF) begin
              state_d = ST_FINISH;
            end else begin
              addr_d  = addr_q + 8'd1;
              state_d = ST_ISSUE;
            end
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wait_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      cell_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cell_q  <= cell_d;
      if (state_q == ST_DRAW) begin
        x_q      <= x_live;
        y_q      <= y_live;
        colour_q <= colour_live;
      end
    end
  end

  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DRAW);
  assign mode        = busy ? MODE_READ : MODE_NOP;
  assign plot        = (state_q == ST_DRAW);
  assign done        = (state_q == ST_FINISH);
  assign address     = addr_q;
  assign x           = plot ? x_live : x_q;
  assign y           = plot ? y_live : y_q;
  assign colour      = plot ? colour_live : colour_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_board_reader.sv
// Self-checking bench for board_reader: storage model, frame-level pixel
// reference model and scenario tasks. Honours DIRECTION_MARK_EN.
module tb_board_reader;
  import board_pkg::*;

  localparam int CPX   = 4;
  localparam int CPC   = 18;
  localparam int FRAME = 4608;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ram_q = 8'h00;
  logic [3:0] mode;
  logic [7:0] address;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  logic [7:0]  mem [256];
  logic [2:0]  fb [160][120];
  logic [17:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int first_x, first_y, last_x, last_y;

  board_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ram_q       (ram_q),
    .mode        (mode),
    .address     (address),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // storage: data for the held address is ready by the end of WAIT
  always @(posedge clk) ram_q <= mem[address];

  function automatic logic [2:0] ref_colour(input logic [7:0] c, input int px, input int py);
    logic [2:0] col;
    int         bx, by;
    logic [1:0] d;
    if (c[6])      col = 3'b100;
    else if (c[5]) col = 3'b001;
    else if (c[4]) col = 3'b110;
    else if (c[7]) col = 3'b111;
    else           col = 3'b000;
`ifdef DIRECTION_MARK_EN
    if (c[6] || c[5]) begin
      d = c[6] ? c[3:2] : c[1:0];
      case (d)
        2'd0:    begin bx = CPX/2;   by = 0;       end
        2'd1:    begin bx = CPX/2;   by = CPX-1;   end
        2'd2:    begin bx = 0;       by = CPX/2;   end
        default: begin bx = CPX-1;   by = CPX/2;   end
      endcase
      if (px == bx && py == by) col = 3'b010;
    end
`else
    bx = px; by = py; d = 2'd0;
`endif
    return col;
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int a = 0; a < 256; a++)
      for (int py = 0; py < CPX; py++)
        for (int px = 0; px < CPX; px++)
          exp_q.push_back({8'(48 + (a % 16) * CPX + px), 7'(28 + (a / 16) * CPX + py),
                           ref_colour(mem[a], px, py)});
  endtask

  // Runs one frame from a start pulse; e1/e2 are cycles with extra start
  // pulses, abort_at (>0) asserts reset in that cycle and abandons the frame.
  task automatic scan_frame(input int e1, input int e2, input int abort_at,
                            output int plots, output int done_cnt, output int done_cyc);
    logic        exp_busy, exp_plot;
    logic [17:0] e;
    build_expected();
    plots = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= FRAME + 6; cyc++) begin
      @(posedge clk); #1;
      exp_busy = (cyc <= FRAME);
      exp_plot = exp_busy && (((cyc - 1) % CPC) >= 2);
      checks++;
      if (busy !== exp_busy) $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
      else passed++;
      checks++;
      if (plot !== exp_plot) $display("FAIL plot cyc=%0d got %b want %b", cyc, plot, exp_plot);
      else passed++;
      checks++;
      if (done !== (cyc == FRAME + 1)) $display("FAIL done cyc=%0d got %b want %b", cyc, done, cyc == FRAME + 1);
      else passed++;
      checks++;
      if (mode !== (exp_busy ? 4'b0000 : 4'b1110)) $display("FAIL mode cyc=%0d got %h want %h", cyc, mode, exp_busy ? 4'b0000 : 4'b1110);
      else passed++;
      if (exp_busy) begin
        checks++;
        if (address !== 8'((cyc - 1) / CPC)) $display("FAIL address cyc=%0d got %0d want %0d", cyc, address, (cyc - 1) / CPC);
        else passed++;
      end
      if (plot === 1'b1) begin
        plots++;
        if (plots == 1) begin first_x = int'(x); first_y = int'(y); end
        last_x = int'(x); last_y = int'(y);
        if (x < 160 && y < 120) fb[x][y] = colour;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL pixel_extra cyc=%0d got x=%0d y=%0d want no pixel", cyc, x, y);
        end else begin
          e = exp_q.pop_front();
          if ({x, y, colour} !== e)
            $display("FAIL pixel cyc=%0d got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b",
                     cyc, x, y, colour, e[17:10], e[9:3], e[2:0]);
          else passed++;
        end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (cyc == abort_at) begin
        reset = 1'b0; #1;
        checks++;
        if ({plot, busy, done, mode} !== {3'b000, 4'b1110})
          $display("FAIL abort_outputs got plot=%b busy=%b done=%b mode=%h want 0 0 0 e", plot, busy, done, mode);
        else passed++;
        checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL abort_state got %0d want %0d", dbg_state, ST_IDLE);
        else passed++;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        return;
      end
      start = (cyc == e1) || (cyc == e2);
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int plots, input int done_cnt, input int done_cyc);
    checks++;
    if (plots !== 4096) $display("FAIL %s_plots got %0d want 4096", tag, plots);
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL %s_done_count got %0d want 1", tag, done_cnt);
    else passed++;
    checks++;
    if (done_cyc !== FRAME + 1) $display("FAIL %s_done_cycle got %0d want %0d", tag, done_cyc, FRAME + 1);
    else passed++;
  endtask

  task automatic test_reset();
    logic saw;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mode, address, x, y, colour, plot, busy, done} !== {4'b1110, 8'd0, 8'd0, 7'd0, 3'd0, 3'b000})
      $display("FAIL reset_values got mode=%h addr=%0d x=%0d y=%0d c=%b p=%b b=%b d=%b want e 0 0 0 0 0 0 0",
               mode, address, x, y, colour, plot, busy, done);
    else passed++;
    @(negedge clk); reset = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      saw = saw | plot | busy | done | (mode != 4'b1110);
    end
    checks++;
    if (saw !== 1'b0) $display("FAIL idle_quiet got activity=%b want 0", saw);
    else passed++;
  endtask

  task automatic test_empty_board();
    int p, dc, dcyc;
    foreach (mem[i]) mem[i] = 8'h00;
    scan_frame(-1, -1, 0, p, dc, dcyc);
    check_frame("empty", p, dc, dcyc);
    checks++;
    if (first_x !== 48 || first_y !== 28) $display("FAIL empty_first got (%0d,%0d) want (48,28)", first_x, first_y);
    else passed++;
    checks++;
    if (last_x !== 111 || last_y !== 91) $display("FAIL empty_last got (%0d,%0d) want (111,91)", last_x, last_y);
    else passed++;
  endtask

  task automatic test_cell_contents();
    int p, dc, dcyc;
    logic [2:0] want_mark;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h00] = 8'h40;
    mem[8'h1F] = 8'h80;
    mem[8'h22] = 8'h70;
    mem[8'h55] = 8'h4C;
    scan_frame(-1, -1, 0, p, dc, dcyc);
    check_frame("cells", p, dc, dcyc);
    checks++;
    if (fb[48][28] !== 3'b100 || fb[51][31] !== 3'b100) $display("FAIL cell00_red got %b/%b want 100", fb[48][28], fb[51][31]);
    else passed++;
    checks++;
    if (fb[108][32] !== 3'b111 || fb[111][35] !== 3'b111) $display("FAIL cell1f_white got %b/%b want 111", fb[108][32], fb[111][35]);
    else passed++;
    checks++;
    if (fb[56][36] !== 3'b100) $display("FAIL cell22_priority got %b want 100", fb[56][36]);
    else passed++;
`ifdef DIRECTION_MARK_EN
    want_mark = 3'b010;
`else
    want_mark = 3'b100;
`endif
    checks++;
    if (fb[71][50] !== want_mark) $display("FAIL cell55_barrel got %b want %b", fb[71][50], want_mark);
    else passed++;
    checks++;
    if (fb[70][50] !== 3'b100 || fb[71][51] !== 3'b100) $display("FAIL cell55_body got %b/%b want 100", fb[70][50], fb[71][51]);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int p, dc, dcyc;
    foreach (mem[i]) mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    scan_frame(100, FRAME, 0, p, dc, dcyc);
    check_frame("busy_start", p, dc, dcyc);
  endtask

  task automatic test_random_board();
    int p, dc, dcyc;
    foreach (mem[i]) mem[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
    // start in the same cycle as done must be dropped
    scan_frame(FRAME + 1, -1, 0, p, dc, dcyc);
    check_frame("random", p, dc, dcyc);
  endtask

  task automatic test_reset_mid_scan();
    int p, dc, dcyc;
    foreach (mem[i]) mem[i] = 8'($urandom);
    scan_frame(-1, -1, 2000, p, dc, dcyc);
    repeat (3) @(posedge clk);
    scan_frame(-1, -1, 0, p, dc, dcyc);
    check_frame("rescan", p, dc, dcyc);
    checks++;
    if (first_x !== 48 || first_y !== 28) $display("FAIL rescan_first got (%0d,%0d) want (48,28)", first_x, first_y);
    else passed++;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    test_reset();
    test_empty_board();
    test_cell_contents();
    test_start_while_busy();
    test_random_board();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/board_reader.md
Name: board_reader

Overview:
Read-side scanner for the 16x16 game board held in storage.
- Sweeps all 256 board cells using storage read mode (4'b0000).
- Captures each returned cell byte and decodes it to a colour.
- Emits one plot strobe per pixel to the VGA adapter, drawing each cell as a CELL_PX x CELL_PX square.
- Sits between storage and the VGA adapter. It is started once per frame by the game controller.

Parameters:
CELL_PX, 4, pixels per cell edge; power of two, 2..8
X_OFFSET, 48, screen x of cell column 0; X_OFFSET+16*CELL_PX <= 160
Y_OFFSET, 28, screen y of cell row 0; Y_OFFSET+16*CELL_PX <= 120
READ_LATENCY, 2, clocks from address issue to valid ram_q (RAM 1 + storage output register 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to scan a frame; ignored while busy
ram_q  in  8  cell byte from storage updated_pos
mode  out  4  storage mode; READ (4'b0000) while busy, NOP (4'b1110) otherwise
address  out  8  cell address; [7:4] row, [3:0] column
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour {R,G,B}
plot  out  1  pixel write strobe, one pixel per cycle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final pixel

Behaviour:
- Reset values (asynchronous, reset low): state IDLE; mode=NOP; address=0; x=0; y=0; colour=0; plot=0; busy=0; done=0.
- States: IDLE, ISSUE, WAIT, DRAW, FINISH.
- IDLE: start=1 -> ISSUE, with address=0 and busy=1.
- ISSUE: one cycle with mode=READ and the address driven -> WAIT.
- WAIT: lasts READ_LATENCY-1 cycles. On its last cycle, ram_q is registered into cell_q -> DRAW.
- Address and mode=READ are held stable from ISSUE through the end of DRAW.
- DRAW: CELL_PX*CELL_PX cycles with plot=1.
  - Pixel counters px (fast), then py.
  - x = X_OFFSET + col*CELL_PX + px.
  - y = Y_OFFSET + row*CELL_PX + py.
- End of DRAW:
  - address != 255: address increments, then -> ISSUE.
  - address == 255: -> FINISH.
- FINISH: done=1 for one cycle; busy=0, mode=NOP -> IDLE. No address wrap occurs within a frame.
- Cell byte layout: [7] wall, [6] tank1, [5] tank2, [4] projectile, [3:2] tank1 dir, [1:0] tank2 dir.
- Dir encoding: 0 up, 1 down, 2 left, 3 right.
- Colour priority, highest first:
  - tank1 -> 3'b100 red
  - tank2 -> 3'b001 blue
  - projectile -> 3'b110 yellow
  - wall -> 3'b111 white
  - empty -> 3'b000 black
- x, y and colour are only meaningful while plot=1. They hold their last values otherwise.
- Timing: cycles per cell = 1 + (READ_LATENCY-1) + CELL_PX^2, which is 18 at defaults. A frame is 256*18 = 4608 cycles from ISSUE of cell 0 to the last plot; done follows on the next cycle.
- start while busy or in FINISH is ignored, not queued. start in the same cycle as done is also ignored.
- Reset asserted mid-scan: immediate return to reset values; a partial frame is abandoned.

Optional Feature:
Macro DIRECTION_MARK_EN.
- Defined: in a cell with tank1 or tank2 set, one barrel pixel is drawn green (3'b010) instead of the body colour.
- The barrel pixel is chosen by the winning tank's dir field:
  - up: (px=CELL_PX/2, py=0)
  - down: (CELL_PX/2, CELL_PX-1)
  - left: (0, CELL_PX/2)
  - right: (CELL_PX-1, CELL_PX/2)
- Undefined: the cell is drawn in solid colour and the dir bits are ignored.
- Timing is identical either way.

Decomposition:
- Package board_pkg holds:
  - mode constants MODE_READ=4'b0000 and MODE_NOP=4'b1110
  - cell bit-index constants (WALL=7, TANK1=6, TANK2=5, PROJ=4, DIR1 3:2, DIR2 1:0)
  - direction constants (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - colour constants
- One natural sub-module, cell_colour_decode: combinational, cell byte plus px/py -> colour, and owns the DIRECTION_MARK_EN logic.
- The FSM and counters stay in board_reader.

Test Plan:
- Reset: hold reset=0 and toggle clk; then release with no start -> all outputs 0 except mode=4'b1110; plot never asserts.
- Empty board: storage model returns 0x00 with 2-cycle latency; pulse start -> 4096 plots, all colour 000; first pixel (48,28), last (111,91); done pulses on cycle 4609 after start; busy falls with done.
- Cell contents:
  - Cell 0x00=0x40 -> 16 red pixels at x 48..51, y 28..31.
  - Cell 0x1F=0x80 -> white at x 108..111, y 32..35.
  - Cell 0x22=0x70 -> red (priority).
- Start pulses while busy: start at cycle 100 and again at cycle 4608 -> exactly one frame of 4096 plots, a single done pulse.
- Reset mid-scan: assert reset at cycle 2000 -> plot=0 and busy=0 immediately; a later start rescans from address 0.
- DIRECTION_MARK_EN defined, cell 0x55=0x4C (tank1, dir right) -> the pixel at px=3, py=2 (x=71, y=50) is 3'b010 and the other 15 pixels are red.
